// File: rtl/tetris_input_conditioner_pkg.sv
// tetris_input_conditioner_pkg: button indices, repeat FSM encodings and counter sizing
package tetris_input_conditioner_pkg;

    localparam int BTN_ROT   = 0;
    localparam int BTN_LEFT  = 1;
    localparam int BTN_RIGHT = 2;
    localparam int BTN_DOWN  = 3;

    localparam logic [2:0] S_IDLE        = 3'd0;
    localparam logic [2:0] S_HOLD_DELAY  = 3'd1;
    localparam logic [2:0] S_HOLD_REPEAT = 3'd2;
    localparam logic [2:0] S_HOLD_NOREP  = 3'd3;
    localparam logic [2:0] S_WAIT_REL    = 3'd4;

    // Width able to hold 0..limit-1, never zero bits.
    function automatic int cnt_w(input int limit);
        return (limit > 1) ? $clog2(limit) : 1;
    endfunction

endpackage

// File: rtl/tetris_input_conditioner_btn_debounce.sv
// btn_debounce: synchroniser chain plus stable-count debouncer for one button
module btn_debounce
    import tetris_input_conditioner_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int CW = cnt_w(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync;
    logic [CW-1:0]          cnt;
    logic                   synced;
    logic                   toggle;

    assign synced = sync[SYNC_STAGES-1];
    assign toggle = (synced != level) && (cnt == LAST);
    // rise/fall announce the level change that the next edge commits
    assign rise   = toggle && !level;
    assign fall   = toggle && level;

    // Shift the raw pin through the synchroniser chain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync <= '0;
        else        sync <= {sync[SYNC_STAGES-2:0], raw};
    end

    // Count consecutive differing samples; any agreeing sample restarts the count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            level <= 1'b0;
        end else begin
            cnt   <= (synced == level || toggle) ? '0 : (cnt == LAST) ? cnt : cnt + CW'(1);
            level <= level ^ toggle;
        end
    end

endmodule

// File: rtl/tetris_input_conditioner.sv
// tetris_input_conditioner: debounced buttons to one-cycle move pulses with auto-repeat
module tetris_input_conditioner
    import tetris_input_conditioner_pkg::*;
#(
    parameter int               N_BTN           = 4,
    parameter int               SYNC_STAGES     = 2,
    parameter int               DEBOUNCE_CYCLES = 1_000_000,
    parameter int               REPEAT_DELAY    = 25_000_000,
    parameter int               REPEAT_RATE     = 5_000_000,
    parameter logic [N_BTN-1:0] REPEAT_MASK     = ~N_BTN'(1 << BTN_ROT)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] move_pulse,
    output logic             any_press
);

    localparam int RW = cnt_w(REPEAT_DELAY > REPEAT_RATE ? REPEAT_DELAY : REPEAT_RATE);
    localparam logic [RW-1:0] DLAST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RLAST = RW'(REPEAT_RATE - 1);

    logic [N_BTN-1:0] rise;
    logic [N_BTN-1:0] fall;
    logic [N_BTN-1:0] fire;

    for (genvar g = 0; g < N_BTN; g++) begin : g_btn
        logic [2:0]    state;
        logic [2:0]    state_nxt;
        logic [RW-1:0] cnt;
        logic [RW-1:0] cnt_nxt;
        logic          f;

        btn_debounce #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_db (
            .clk  (clk),
            .rst_n(rst_n),
            .raw  (btn_raw[g]),
            .level(btn_level[g]),
            .rise (rise[g]),
            .fall (fall[g])
        );

        // Repeat FSM: press pulse, delayed first repeat, then periodic repeats while held
        always_comb begin
            state_nxt = state;
            cnt_nxt   = (cnt == '1) ? cnt : cnt + RW'(1);
            f         = 1'b0;
            case (state)
                S_IDLE: begin
                    if (rise[g] && en) begin
                        f         = 1'b1;
                        cnt_nxt   = '0;
                        state_nxt = REPEAT_MASK[g] ? S_HOLD_DELAY : S_HOLD_NOREP;
                    end
                end
                S_WAIT_REL: begin
                    if (!btn_level[g] || fall[g]) state_nxt = S_IDLE;
                end
                default: begin
                    if (!en) begin
                        state_nxt = S_WAIT_REL;
                    end else if (fall[g]) begin
                        state_nxt = S_IDLE;
                    end else if (state == S_HOLD_DELAY && cnt == DLAST) begin
                        f         = 1'b1;
                        cnt_nxt   = '0;
                        state_nxt = S_HOLD_REPEAT;
                    end else if (state == S_HOLD_REPEAT && cnt == RLAST) begin
                        f         = 1'b1;
                        cnt_nxt   = '0;
                    end
                end
            endcase
        end

        assign fire[g] = f;

        // Commit FSM state and hold counter
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state <= S_IDLE;
                cnt   <= '0;
            end else begin
                state <= state_nxt;
                cnt   <= cnt_nxt;
            end
        end
    end

    // Register the pulses so the core and audio block see clean one-cycle strobes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            move_pulse <= '0;
            any_press  <= 1'b0;
        end else begin
            move_pulse <= fire;
            any_press  <= |fire;
        end
    end

endmodule
